// File: rtl/shiftreg8_pkg.sv
// shiftreg8_pkg: shared constants and FSM encoding for the shiftreg8 sequencer.
package shiftreg8_pkg;
  localparam int SR_STAGES = 3;
  localparam int DELAY_W = 2;
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, SWITCH = 2'd2} state_t;
endpackage

// File: rtl/shiftreg8_seq_if.sv
// shiftreg8_seq_if: sample stream, delay-config handshake and status of the sequencer.
interface shiftreg8_seq_if #(parameter int CNT_W = 16);
  import shiftreg8_pkg::*;
  logic in_valid;
  logic [7:0] in_data;
  logic in_ready;
  logic cfg_valid;
  logic [DELAY_W-1:0] cfg_delay;
  logic cfg_ready;
  logic out_valid;
  logic [7:0] out_data;
  logic [DELAY_W-1:0] cur_delay;
  logic busy;
  logic [CNT_W-1:0] out_cnt;
  modport slave (
    input in_valid, in_data, cfg_valid, cfg_delay,
    output in_ready, cfg_ready, out_valid, out_data, cur_delay, busy, out_cnt
  );
  modport master (
    output in_valid, in_data, cfg_valid, cfg_delay,
    input in_ready, cfg_ready, out_valid, out_data, cur_delay, busy, out_cnt
  );
endinterface

// File: rtl/shiftreg8_3.sv
// shiftreg8_3: 3-stage 8-bit shift register with tap select; sel=0 is a combinational bypass.
module shiftreg8_3
  import shiftreg8_pkg::*;
(
  input  logic               clk,
  input  logic [7:0]         i_d,
  input  logic [DELAY_W-1:0] i_sel,
  output logic [7:0]         o_q
);
  logic [7:0] r_s1, r_s2, r_s3;
  always_ff @(posedge clk) begin
    r_s1 <= i_d;
    r_s2 <= r_s1;
    r_s3 <= r_s2;
  end
  assign o_q = (i_sel == 2'd0) ? i_d :
               (i_sel == 2'd1) ? r_s1 :
               (i_sel == 2'd2) ? r_s2 : r_s3;
endmodule

// File: rtl/shiftreg8_seq.sv
// shiftreg8_seq: valid-tagged wrapper around shiftreg8_3 that drains in-flight
// samples before applying a new tap, so reconfiguration never drops or repeats data.
module shiftreg8_seq
  import shiftreg8_pkg::*;
#(
  parameter logic [DELAY_W-1:0] RST_DELAY = 2'd0,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  shiftreg8_seq_if.slave bus
);
  state_t r_state;
  logic [DELAY_W-1:0] r_cur_delay, r_new_delay, r_cnt;
  logic [SR_STAGES:1] r_vld;
  logic [CNT_W-1:0] r_out_cnt;
  logic [SR_STAGES:0] w_tap;
  logic [7:0] w_q;
  logic w_in_ready, w_accept, w_out_valid;

  assign w_in_ready = (r_state == RUN) && !bus.cfg_valid;
  assign w_accept = bus.in_valid && w_in_ready;
  assign w_tap = {r_vld, w_accept};
  assign w_out_valid = w_tap[r_cur_delay];
  assign bus.in_ready = w_in_ready;
  assign bus.cfg_ready = r_state == SWITCH;
  assign bus.busy = r_state != RUN;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data = w_out_valid ? w_q : 8'h00;
  assign bus.cur_delay = r_cur_delay;
  assign bus.out_cnt = r_out_cnt;

  shiftreg8_3 u_sr (
    .clk  (clk),
    .i_d  (bus.in_data),
    .i_sel(r_cur_delay),
    .o_q  (w_q)
  );

  // Clearing the tags on the switch edge stops already-emitted samples from reappearing at the new tap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cur_delay <= RST_DELAY;
      r_new_delay <= '0;
      r_cnt <= '0;
      r_vld <= '0;
      r_out_cnt <= '0;
    end else begin
      r_vld <= (r_state == SWITCH) ? '0 : {r_vld[SR_STAGES-1:1], w_accept};
      r_out_cnt <= r_out_cnt + CNT_W'(w_out_valid);
      case (r_state)
        RUN: if (bus.cfg_valid) begin
          r_new_delay <= bus.cfg_delay;
          r_cnt <= r_cur_delay - DELAY_W'(1);
          r_state <= (r_cur_delay <= 2'd1) ? SWITCH : DRAIN;
        end
        DRAIN: begin
          r_cnt <= r_cnt - DELAY_W'(1);
          if (r_cnt == 2'd1) r_state <= SWITCH;
        end
        SWITCH: begin
          r_cur_delay <= r_new_delay;
          r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_shiftreg8_seq.sv
// tb_shiftreg8_seq: vector table, directed reconfiguration sequences and random traffic
// checked against a timeline model (sample emitted at accept cycle + delay).
module tb_shiftreg8_seq;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  shiftreg8_seq_if #(.CNT_W(CW)) bus();
  shiftreg8_seq #(.RST_DELAY(2'd0), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    bit iv; logic [7:0] d; bit cv; logic [1:0] cd;
    bit ir; bit ov; logic [7:0] od; bit cr; bit busy; logic [1:0] cur; int cnt;
  } vec_t;
  vec_t tbl[$];

  int checks = 0, errors = 0, cyc = 0, lo_cnt = 0;
  int hits[256];
  logic [7:0] em[int];
  logic [1:0] m_delay, m_new;
  bit m_pend;
  int m_rdy_t;
  logic [CW-1:0] m_cnt;
  logic a_ir, a_ov, a_cr, a_busy;
  logic [7:0] a_od;
  logic [1:0] a_cur;
  logic [CW-1:0] a_cnt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sample();
    a_ir = bus.in_ready; a_ov = bus.out_valid; a_od = bus.out_data; a_cr = bus.cfg_ready;
    a_busy = bus.busy; a_cur = bus.cur_delay; a_cnt = bus.out_cnt;
  endtask

  task automatic model_reset();
    em.delete();
    m_delay = 2'd0; m_new = 2'd0; m_pend = 1'b0; m_cnt = '0;
  endtask

  task automatic step(input bit iv, input logic [7:0] d, input bit cv, input logic [1:0] cd);
    bit e_ir, e_ov;
    logic [7:0] e_od;
    @(negedge clk);
    bus.in_valid = iv; bus.in_data = d; bus.cfg_valid = cv; bus.cfg_delay = cd;
    #1;
    sample();
    e_ir = !m_pend && !cv;
    if (e_ir && iv) em[cyc + int'(m_delay)] = d;
    e_ov = em.exists(cyc);
    e_od = e_ov ? em[cyc] : 8'h00;
    chk("in_ready", int'(a_ir), int'(e_ir));
    chk("out_valid", int'(a_ov), int'(e_ov));
    chk("out_data", int'(a_od), int'(e_od));
    chk("cfg_ready", int'(a_cr), int'(m_pend && cyc == m_rdy_t));
    chk("busy", int'(a_busy), int'(m_pend && !(cv && !m_pend) && (cyc > m_rdy_t - (m_delay == 0 ? 1 : int'(m_delay)))));
    chk("cur_delay", int'(a_cur), int'(m_delay));
    chk("out_cnt", int'(a_cnt), int'(m_cnt));
    if (a_ov) hits[a_od]++;
    if (!a_ir) lo_cnt++;
    if (e_ov) begin m_cnt++; em.delete(cyc); end
    if (!m_pend && cv) begin
      m_pend = 1'b1; m_new = cd;
      m_rdy_t = cyc + (m_delay == 0 ? 1 : int'(m_delay));
    end else if (m_pend && cyc == m_rdy_t) begin
      m_delay = m_new; m_pend = 1'b0;
    end
    cyc++;
  endtask

  task automatic do_reset(input bit iv, input logic [7:0] d);
    @(negedge clk);
    rst_n = 1'b0; bus.in_valid = iv; bus.in_data = d; bus.cfg_valid = 1'b0; bus.cfg_delay = 2'd0;
    #1;
    sample();
    chk("rst_in_ready", int'(a_ir), 1);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_cfg_ready", int'(a_cr), 0);
    chk("rst_cur_delay", int'(a_cur), 0);
    chk("rst_out_cnt", int'(a_cnt), 0);
    chk("rst_out_valid", int'(a_ov), int'(iv));
    chk("rst_out_data", int'(a_od), iv ? int'(d) : 0);
    @(negedge clk);
    bus.in_valid = 1'b0; rst_n = 1'b1;
    model_reset();
  endtask

  task automatic cfg_change(input logic [1:0] nd, input bit iv, input logic [7:0] d, output int n);
    n = 0;
    do begin step(iv, d, 1'b1, nd); n++; end while (!a_cr && n < 8);
    chk("cfg_ready_seen", int'(a_cr), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n, first;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.cfg_valid = 1'b0; bus.cfg_delay = 2'd0;
    model_reset();
    tbl.push_back('{1'b1, 8'h01, 1'b0, 2'd0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 2'd0, 0});
    tbl.push_back('{1'b1, 8'h02, 1'b0, 2'd0, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 2'd0, 1});
    tbl.push_back('{1'b1, 8'h03, 1'b0, 2'd0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 2'd0, 2});
    tbl.push_back('{1'b1, 8'h04, 1'b0, 2'd0, 1'b1, 1'b1, 8'h04, 1'b0, 1'b0, 2'd0, 3});
    tbl.push_back('{1'b1, 8'h05, 1'b0, 2'd0, 1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 2'd0, 4});
    tbl.push_back('{1'b1, 8'h06, 1'b1, 2'd2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 5});
    tbl.push_back('{1'b1, 8'h06, 1'b1, 2'd2, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 5});
    tbl.push_back('{1'b1, 8'h10, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd2, 5});
    tbl.push_back('{1'b1, 8'h11, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd2, 5});
    tbl.push_back('{1'b1, 8'h12, 1'b0, 2'd0, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 2'd2, 5});
    tbl.push_back('{1'b1, 8'h13, 1'b0, 2'd0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 2'd2, 6});
    tbl.push_back('{1'b1, 8'h14, 1'b0, 2'd0, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 2'd2, 7});
    tbl.push_back('{1'b1, 8'h15, 1'b1, 2'd2, 1'b0, 1'b1, 8'h13, 1'b0, 1'b0, 2'd2, 8});
    tbl.push_back('{1'b1, 8'h15, 1'b1, 2'd2, 1'b0, 1'b1, 8'h14, 1'b0, 1'b1, 2'd2, 9});
    tbl.push_back('{1'b1, 8'h15, 1'b1, 2'd2, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd2, 10});
    tbl.push_back('{1'b1, 8'h15, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd2, 10});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd2, 10});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b1, 8'h15, 1'b0, 1'b0, 2'd2, 10});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd2, 11});

    do_reset(1'b1, 8'h5a);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].iv, tbl[i].d, tbl[i].cv, tbl[i].cd);
      chk("tv_in_ready", int'(a_ir), int'(tbl[i].ir));
      chk("tv_out_valid", int'(a_ov), int'(tbl[i].ov));
      chk("tv_out_data", int'(a_od), int'(tbl[i].od));
      chk("tv_cfg_ready", int'(a_cr), int'(tbl[i].cr));
      chk("tv_busy", int'(a_busy), int'(tbl[i].busy));
      chk("tv_cur_delay", int'(a_cur), int'(tbl[i].cur));
      chk("tv_out_cnt", int'(a_cnt), tbl[i].cnt);
    end

    // delay 1 -> 3 mid-stream
    cfg_change(2'd1, 1'b0, 8'h00, n);
    foreach (hits[i]) hits[i] = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 2'd0);
    cfg_change(2'd3, 1'b1, 8'h28, n);
    chk("lat_1to3", n, 2);
    first = -1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'h28 + 8'(i), 1'b0, 2'd0);
      if (a_ov && first < 0) first = i;
    end
    chk("first_new_1to3", first, 3);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 2'd0);
    chk("once_27", hits[8'h27], 1);
    chk("once_28", hits[8'h28], 1);

    // delay 3 -> 0 with cfg_delay wiggling while pending
    foreach (hits[i]) hits[i] = 0;
    for (int i = 0; i < 7; i++) step(1'b1, 8'h3a + 8'(i), 1'b0, 2'd0);
    lo_cnt = 0;
    step(1'b1, 8'h41, 1'b1, 2'd0);
    n = 1;
    while (!a_cr && n < 8) begin step(1'b1, 8'h41, 1'b1, 2'($urandom)); n++; end
    chk("lat_3to0", n, 4);
    step(1'b1, 8'h41, 1'b0, 2'd0);
    chk("ir_low_3to0", lo_cnt, 4);
    chk("bypass_valid", int'(a_ov), 1);
    chk("bypass_data", int'(a_od), 8'h41);
    chk("once_3e", hits[8'h3e], 1);
    chk("once_3f", hits[8'h3f], 1);
    chk("once_40", hits[8'h40], 1);

    // same-delay request 0 -> 0 still takes the switch cycle
    cfg_change(2'd0, 1'b1, 8'h42, n);
    chk("lat_0to0", n, 2);

    // reset asserted while draining
    cfg_change(2'd3, 1'b0, 8'h00, n);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h50 + 8'(i), 1'b0, 2'd0);
    step(1'b1, 8'h54, 1'b1, 2'd2);
    step(1'b0, 8'h00, 1'b1, 2'd2);
    chk("busy_drain", int'(a_busy), 1);
    do_reset(1'b0, 8'h00);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 8'h00, 1'b0, 2'd0);
      n += int'(a_cr);
    end
    chk("no_cfg_ready_after_rst", n, 0);
    chk("ir_after_rst", int'(a_ir), 1);
    step(1'b1, 8'h60, 1'b0, 2'd0);
    chk("post_rst_bypass", int'(a_od), 8'h60);

    // counter wrap
    do_reset(1'b0, 8'h00);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 2'd0);
    chk("cnt_all_ones", int'(a_cnt), 15);
    step(1'b0, 8'h00, 1'b0, 2'd0);
    chk("cnt_wrap", int'(a_cnt), 0);

    // random traffic, occasional dropped cfg_valid while pending
    for (int i = 0; i < 800; i++) begin
      bit cv;
      if (i == 400) do_reset(1'b0, 8'h00);
      cv = m_pend ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 7) == 0);
      step($urandom_range(0, 3) != 0, 8'($urandom), cv, 2'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
